// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU sequencer: FSM states, instruction fields, opcodes.
// Build option ALU_SEQUENCER_CMP_EN is consumed by alu_sequencer.sv.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_t;

  localparam int BSEL_B = 19;
  localparam int OP_HI  = 18;
  localparam int OP_LO  = 15;
  localparam int RD_HI  = 14;
  localparam int RD_LO  = 13;
  localparam int RS_HI  = 12;
  localparam int RS_LO  = 11;
  localparam int RT_HI  = 10;
  localparam int RT_LO  = 9;
  localparam int NOWB_B = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef struct packed {
    logic       bsel;
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [1:0] rt;
    logic       nowb;
    logic [7:0] imm;
  } instr_t;

  function automatic instr_t decode(
    input logic [19:0] w
  );
    instr_t d;
    d.bsel = w[BSEL_B];
    d.op   = w[OP_HI:OP_LO];
    d.rd   = w[RD_HI:RD_LO];
    d.rs   = w[RS_HI:RS_LO];
    d.rt   = w[RT_HI:RT_LO];
    d.nowb = w[NOWB_B];
    d.imm  = w[IMM_HI:IMM_LO];
    return d;
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// 4x8 register file: one write port, two operand reads, one debug read.
// All reads are combinational; reset clears every entry.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int NREGS = 4,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [7:0]    rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [7:0]    rdata_b,
  input  logic [AW-1:0] dbg_addr,
  output logic [7:0]    dbg_data
);

  logic [7:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Three-state sequencer driving an external 8-bit ALU with register write-back.
// Define ALU_SEQUENCER_CMP_EN to let nowb suppress ALU-op write-back.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int INSTR_W = 20,
  parameter int NREGS   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  output logic [7:0]         alu_opcode,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  input  logic [7:0]         alu_result,
  input  logic               alu_zero,
  input  logic               alu_carry,
  input  logic               alu_negative,
  output logic               flag_z,
  output logic               flag_c,
  output logic               flag_n,
  output logic               done,
  output logic [1:0]         wb_addr,
  output logic [7:0]         wb_data,
  output logic               halted,
  input  logic [1:0]         dbg_addr,
  output logic [7:0]         dbg_data
);

`ifdef ALU_SEQUENCER_CMP_EN
  localparam bit CMP_EN = 1'b1;
`else
  localparam bit CMP_EN = 1'b0;
`endif

  state_t     state_q;
  state_t     state_d;
  instr_t     dec;
  logic       accept;

  logic [3:0] op_q;
  logic [1:0] rd_q;
  logic       nowb_q;
  logic [7:0] imm_q;

  logic [7:0] res_q;
  logic       z_q;
  logic       c_q;
  logic       n_q;

  logic       rf_we;
  logic [7:0] rf_wdata;
  logic [7:0] rdata_a;
  logic [7:0] rdata_b;

  assign dec = decode(instr);

  alu_seq_regfile #(
    .NREGS(NREGS)
  ) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (rd_q),
    .wdata    (rf_wdata),
    .raddr_a  (dec.rs),
    .rdata_a  (rdata_a),
    .raddr_b  (dec.rt),
    .rdata_b  (rdata_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  assign instr_ready = (state_q == IDLE) && !halted;
  assign done        = (state_q == WB);

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    rf_we    = 1'b0;
    rf_wdata = res_q;
    unique case (state_q)
      IDLE: begin
        if (instr_valid && instr_ready) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: state_d = WB;
      WB: begin
        state_d = IDLE;
        unique case (1'b1)
          (op_q == OP_LDI): begin
            rf_we    = 1'b1;
            rf_wdata = imm_q;
          end
          (op_q == OP_HALT): rf_we = 1'b0;
          default: rf_we = !(CMP_EN && nowb_q);
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operands are sampled at accept, so they stay put until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      rd_q       <= '0;
      nowb_q     <= 1'b0;
      imm_q      <= '0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
    end else if (accept) begin
      op_q       <= dec.op;
      rd_q       <= dec.rd;
      nowb_q     <= dec.nowb;
      imm_q      <= dec.imm;
      alu_opcode <= {4'b0, dec.op};
      alu_a      <= rdata_a;
      alu_b      <= dec.bsel ? dec.imm : rdata_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      n_q   <= 1'b0;
    end else if (state_q == EXEC) begin
      res_q <= alu_result;
      z_q   <= alu_zero;
      c_q   <= alu_carry;
      n_q   <= alu_negative;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      flag_n  <= 1'b0;
      halted  <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else if (state_q == WB) begin
      unique case (1'b1)
        (op_q == OP_LDI): begin
          flag_z <= (imm_q == 8'h00);
          flag_n <= imm_q[7];
        end
        (op_q == OP_HALT): halted <= 1'b1;
        default: begin
          flag_z <= z_q;
          flag_c <= c_q;
          flag_n <= n_q;
        end
      endcase
      if (rf_we) begin
        wb_addr <= rd_q;
        wb_data <= rf_wdata;
      end
    end
  end

endmodule
